// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator-side sequencer for a registered 32-bit ALU.
// Takes one request at a time and decodes it into ALU operands and an
// operation select. It waits out the ALU latency, captures the result,
// and returns it on a valid/ready response channel.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_sr1,
  output logic [31:0]      alu_sr2,
  output logic [2:0]       alu_os,
  output logic [31:0]      alu_shift,
  input  logic [31:0]      alu_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROT = 4'd6;
  localparam logic [3:0] OP_SUB = 4'd7;

  // The wait counter only has to hold 1..7.
  localparam logic [2:0]       LAT_INIT = 3'(ALU_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      sr1_q, sr1_d;
  logic [31:0]      sr2_q, sr2_d;
  logic [2:0]       os_q, os_d;
  logic [31:0]      shift_q, shift_d;
  logic [2:0]       wait_q, wait_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rzero_q, rzero_d;
  logic             rerr_q, rerr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // SUB is issued to the ALU as an ADD of the two's complement of B.
  function automatic logic [31:0] twos_neg(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Illegal opcodes skip the ALU and go straight to the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = req_op[3] ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_q == 3'd0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs come straight from the registered state, so there is no combinational ready path.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  // Datapath register bank: latched request, ALU operands, wait counter, response, counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sr1_q   <= 32'd0;
      sr2_q   <= 32'd0;
      os_q    <= 3'd0;
      shift_q <= 32'd0;
      wait_q  <= 3'd0;
      rdata_q <= 32'd0;
      rzero_q <= 1'b0;
      rerr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      os_q    <= os_d;
      shift_q <= shift_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      rzero_q <= rzero_d;
      rerr_q  <= rerr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath next values. Everything holds unless the current state says otherwise.
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    os_d    = os_q;
    shift_d = shift_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    rzero_d = rzero_q;
    rerr_d  = rerr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (req_op[3]) begin
            rdata_d = 32'd0;
            rzero_d = 1'b0;
            rerr_d  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        sr1_d = a_q;
        if (op_q == OP_SUB) begin
          sr2_d = twos_neg(b_q);
          os_d  = 3'b000;
        end else begin
          sr2_d = b_q;
          os_d  = op_q[2:0];
        end
        shift_d = ((op_q == OP_SHL) || (op_q == OP_ROT)) ? b_q : 32'd0;
        wait_d  = LAT_INIT;
      end
      S_WAIT: begin
        if (wait_q == 3'd0) begin
          rdata_d = alu_rd;
          rzero_d = (alu_rd == 32'd0);
          rerr_d  = 1'b0;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Output mapping.
  always_comb begin
    alu_sr1   = sr1_q;
    alu_sr2   = sr2_q;
    alu_os    = os_q;
    alu_shift = shift_q;
    rsp_data  = rdata_q;
    rsp_zero  = rzero_q;
    rsp_err   = rerr_q;
    op_count  = cnt_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a registered ALU model, a cycle-level
// behavioural reference checked every cycle, directed literal cases and
// randomized traffic.
module tb_alu_issue_ctrl;

  localparam int LAT = 1;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [3:0]    req_op = 4'd0;
  logic [31:0]   req_a = 32'd0;
  logic [31:0]   req_b = 32'd0;
  logic          req_ready;
  logic [31:0]   alu_sr1, alu_sr2, alu_shift, alu_rd;
  logic [2:0]    alu_os;
  logic          rsp_valid, rsp_zero, rsp_err;
  logic [31:0]   rsp_data;
  logic [CW-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_sr1(alu_sr1), .alu_sr2(alu_sr2), .alu_os(alu_os), .alu_shift(alu_shift),
    .alu_rd(alu_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .op_count(op_count)
  );

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < 32; i++) if (i < int'(s)) r = {r[30:0], r[31]};
    return r;
  endfunction

  // Registered ALU with LAT pipeline stages.
  function automatic logic [31:0] alu_f(input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [2:0] os, input logic [31:0] sh);
    case (os)
      3'd0: return s1 + s2;
      3'd1: return s1 | s2;
      3'd2: return s1 & s2;
      3'd3: return s1 ^ s2;
      3'd4: return ~(s1 | s2);
      3'd5: return s1 << sh[4:0];
      3'd6: return rotl(s1, sh[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_sr1, alu_sr2, alu_os, alu_shift);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_rd = alu_pipe[LAT-1];

  // Architectural meaning of each request opcode.
  function automatic logic [31:0] op_result(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a | b;
      4'd2: return a & b;
      4'd3: return a ^ b;
      4'd4: return ~(a | b);
      4'd5: return a << b[4:0];
      4'd6: return rotl(a, b[4:0]);
      4'd7: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one request outstanding, response visible a fixed number of edges after acceptance.
  bit            m_busy, m_legal, m_zero, m_err;
  int            m_delay, m_issue;
  logic [31:0]   m_data;
  logic [CW-1:0] m_count;
  logic [31:0]   p_sr1, p_sr2, p_sh, e_sr1, e_sr2, e_sh;
  logic [2:0]    p_os, e_os;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 0; m_legal = 0; m_zero = 0; m_err = 0; m_delay = 0; m_issue = 0;
        m_data = 0; m_count = 0;
        e_sr1 = 0; e_sr2 = 0; e_sh = 0; e_os = 0;
      end else begin
        chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_busy && m_delay == 0});
        if (m_busy && m_delay == 0) begin
          chk("rsp_data", rsp_data, m_data);
          chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
          chk("rsp_err",  {31'd0, rsp_err},  {31'd0, m_err});
        end
        chk("op_count",  32'(op_count), 32'(m_count));
        chk("alu_sr1",   alu_sr1, e_sr1);
        chk("alu_sr2",   alu_sr2, e_sr2);
        chk("alu_os",    {29'd0, alu_os}, {29'd0, e_os});
        chk("alu_shift", alu_shift, e_sh);
        // Advance the model across the coming rising edge.
        if (!m_busy) begin
          if (req_valid) begin
            m_busy  = 1;
            m_legal = !req_op[3];
            if (m_legal) begin
              m_data  = op_result(req_op, req_a, req_b);
              m_zero  = (m_data == 0);
              m_err   = 0;
              m_delay = LAT + 2;
              m_issue = 1;
              p_sr1   = req_a;
              p_sr2   = (req_op == 4'd7) ? 32'd0 - req_b : req_b;
              p_os    = (req_op == 4'd7) ? 3'd0 : req_op[2:0];
              p_sh    = (req_op == 4'd5 || req_op == 4'd6) ? req_b : 32'd0;
            end else begin
              m_data = 0; m_zero = 0; m_err = 1; m_delay = 0; m_issue = 0;
            end
          end
        end else begin
          if (m_issue > 0) begin
            m_issue--;
            if (m_issue == 0) begin
              e_sr1 = p_sr1; e_sr2 = p_sr2; e_os = p_os; e_sh = p_sh;
            end
          end
          if (m_delay == 0) begin
            if (rsp_ready) m_busy = 0;
          end else begin
            m_delay--;
            if (m_delay == 0 && m_legal) m_count++;
          end
        end
      end
    end
  end

  // Drive a request until it is accepted; called at posedge+1.
  task automatic issue_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit hs;
    bit done;
    done = 0;
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      hs = req_ready;
      @(posedge clk); #1;
      if (hs) done = 1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready never seen high, op %h", op);
    end
    req_valid = 0;
    req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
  endtask

  // Count edges after the handshake edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    bit done;
    done = 0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (rsp_valid) done = 1;
      else lat++;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid never seen high");
    end
  endtask

  task automatic release_rsp();
    @(posedge clk); #1;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic z, output logic e, output int lat);
    issue_req(op, a, b);
    wait_rsp(lat);
    d = rsp_data; z = rsp_zero; e = rsp_err;
    release_rsp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        z, e;
    int          lat;
    int          guard;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    chk("rst_alu_os",    {29'd0, alu_os}, 32'd0);
    chk("rst_op_count",  32'(op_count), 32'd0);
    reset = 0;
    @(posedge clk); #1;

    do_op(4'd0, 32'h5, 32'h3, d, z, e, lat);
    chk("add_data", d, 32'h8);
    chk("add_zero", {31'd0, z}, 32'd0);
    chk("add_lat", 32'(lat), 32'd3);
    chk("add_os", {29'd0, alu_os}, 32'd0);
    chk("add_cnt", 32'(op_count), 32'd1);

    do_op(4'd7, 32'h1234_5678, 32'h1234_5678, d, z, e, lat);
    chk("sub_sr2", alu_sr2, 32'hEDCB_A988);
    chk("sub_eq_data", d, 32'h0);
    chk("sub_eq_zero", {31'd0, z}, 32'd1);
    do_op(4'd7, 32'h0, 32'h1, d, z, e, lat);
    chk("sub_neg_data", d, 32'hFFFF_FFFF);

    do_op(4'd4, 32'hFFFF_0000, 32'h0000_FFFF, d, z, e, lat);
    chk("nor_data", d, 32'h0);
    chk("nor_zero", {31'd0, z}, 32'd1);
    do_op(4'd0, 32'hFFFF_FFFF, 32'h1, d, z, e, lat);
    chk("add_wrap_data", d, 32'h0);
    chk("add_wrap_zero", {31'd0, z}, 32'd1);

    do_op(4'd5, 32'h1, 32'h4, d, z, e, lat);
    chk("shl_data", d, 32'h10);
    chk("shl_shift", alu_shift, 32'h4);
    do_op(4'd6, 32'h8000_0001, 32'h1, d, z, e, lat);
    chk("rot_data", d, 32'h3);
    do_op(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, d, z, e, lat);
    chk("xor_data", d, 32'hFF00_FF00);

    // Illegal opcode: no ALU issue, error response one edge after acceptance.
    do_op(4'hA, 32'h7, 32'h9, d, z, e, lat);
    chk("ill_err", {31'd0, e}, 32'd1);
    chk("ill_data", d, 32'h0);
    chk("ill_zero", {31'd0, z}, 32'd0);
    chk("ill_lat", 32'(lat), 32'd0);
    chk("ill_os", {29'd0, alu_os}, 32'd3);
    chk("ill_sr1", alu_sr1, 32'hF0F0_F0F0);
    chk("ill_cnt", 32'(op_count), 32'd8);

    // Backpressure with a new request pending.
    issue_req(4'd1, 32'h00FF_0000, 32'h0000_00FF);
    wait_rsp(lat);
    @(posedge clk); #1;
    req_valid = 1; req_op = 4'd2; req_a = 32'hFFFF_0000; req_b = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_data", rsp_data, 32'h00FF_00FF);
    end
    release_rsp();
    issue_req(4'd2, 32'hFFFF_0000, 32'h1234_5678);
    wait_rsp(lat);
    chk("bp_next_data", rsp_data, 32'h1234_0000);
    release_rsp();
    chk("bp_cnt", 32'(op_count), 32'd10);

    // Reset in WAIT aborts the operation.
    issue_req(4'd0, 32'd10, 32'd20);
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_sr1", alu_sr1, 32'd0);
    chk("arst_sr2", alu_sr2, 32'd0);
    chk("arst_shift", alu_shift, 32'd0);
    chk("arst_data", rsp_data, 32'd0);
    chk("arst_cnt", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    do_op(4'd0, 32'd2, 32'd2, d, z, e, lat);
    chk("post_rst_data", d, 32'd4);
    chk("post_rst_cnt", 32'(op_count), 32'd1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      req_a     = $urandom;
      req_b     = ($urandom_range(0, 7) == 0) ? req_a : $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = 0; rsp_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    rsp_ready = 0;

    // Counter wrap.
    guard = 0;
    while (m_count != 8'hFF && guard < 400) begin
      do_op(4'd0, $urandom, $urandom, d, z, e, lat);
      guard++;
    end
    chk("cnt_max", 32'(op_count), 32'hFF);
    do_op(4'd3, 32'h1, 32'h1, d, z, e, lat);
    chk("cnt_wrap", 32'(op_count), 32'd0);
    chk("cnt_wrap_zero", {31'd0, z}, 32'd1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator-side sequencer for the registered 32-bit ALU.
- Accepts one operation request per handshake, decodes the 4-bit request opcode into the ALU's 3-bit operation select, and drives the operand and shift buses.
- Waits the ALU's registered latency, captures the result, and computes the zero flag locally from the captured result.
- Returns result, zero flag and error flag on a valid/ready response channel.
- Sits between the execute-stage control and the ALU instance.

Parameters:
ALU_LAT, 1, clocks from the edge that samples the driven operands to the edge after which the ALU result is stable (1..7)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  4  0 ADD, 1 OR, 2 AND, 3 XOR, 4 NOR, 5 SHL, 6 ROT, 7 SUB, 8-15 illegal
req_a  in  32  operand A
req_b  in  32  operand B; shift/rotate amount for ops 5 and 6
alu_sr1  out  32  ALU operand 1
alu_sr2  out  32  ALU operand 2
alu_os  out  3  ALU operation select
alu_shift  out  32  ALU shift amount
alu_rd  in  32  ALU registered result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  32  result
rsp_zero  out  1  rsp_data == 0
rsp_err  out  1  illegal opcode
op_count  out  CNT_W  completed legal operations, wraps

Behaviour:
- Reset values (asynchronous, applied immediately): state IDLE, req_ready 1, rsp_valid 0, rsp_data 0, rsp_zero 0, rsp_err 0, alu_sr1/alu_sr2/alu_shift 0, alu_os 3'b000, op_count 0, wait counter 0.
- State IDLE
  - req_ready = 1.
  - On req_valid && req_ready, latch the request.
  - Legal op: go to ISSUE.
  - Illegal op (8-15): go to RESP with rsp_err = 1, rsp_data = 0, rsp_zero = 0. No ALU issue, op_count unchanged.
- State ISSUE (1 cycle)
  - Drive operands, which are registered and held stable until the next accepted request.
  - alu_sr1 = A.
  - alu_sr2 = B, except SUB: alu_sr2 = ~B + 1 (mod 2^32) and alu_os = 000.
  - alu_os = req_op[2:0] for ops 0-6.
  - alu_shift = B for ops 5 and 6, otherwise 0.
  - Load wait counter with ALU_LAT, then go to WAIT.
- State WAIT
  - Decrement the wait counter each clock.
  - When the counter reaches 0, capture alu_rd into rsp_data and set rsp_zero = (alu_rd == 0) and rsp_err = 0.
  - Increment op_count (wraps at 2^CNT_W) and go to RESP.
  - With ALU_LAT = 1, total latency from the request handshake edge to rsp_valid high is 3 clocks.
- State RESP
  - rsp_valid = 1; rsp_data, rsp_zero and rsp_err are held stable while rsp_ready = 0 (backpressure may last indefinitely).
  - On rsp_ready, drop rsp_valid on the next edge and go to IDLE.
  - No combinational ready path: the next request can be accepted one clock after the response handshake.
- req_ready is 0 in ISSUE, WAIT and RESP. req_valid and req_* changes in those states are ignored.
- Only one operation is in flight at a time.
- Reset asserted mid-operation aborts it: no response, counter not incremented, all outputs return to reset values.
- Arithmetic is modulo 2^32. SUB of equal operands yields 0 with rsp_zero = 1. ADD overflow is silently wrapped.
- ALU_LAT outside 1..7 is a configuration error and is not supported.

Test Plan:
- ADD A=0x0000_0005, B=0x0000_0003, rsp_ready=1 -> alu_os=000, rsp_data=0x8, rsp_zero=0, rsp_valid 3 clocks after handshake, op_count=1.
- SUB A=0x1234_5678, B=0x1234_5678 -> alu_sr2=0xEDCB_A988, rsp_data=0, rsp_zero=1. Then SUB A=0, B=1 -> rsp_data=0xFFFF_FFFF.
- NOR A=0xFFFF_0000, B=0x0000_FFFF -> rsp_data=0, rsp_zero=1. ADD 0xFFFF_FFFF+1 -> rsp_data=0, rsp_zero=1 (wrap).
- req_op=4'hA -> no ALU issue (alu_os unchanged), rsp_err=1, rsp_data=0, op_count unchanged.
- Backpressure: rsp_ready held 0 for 10 clocks with a new req_valid pending -> rsp_valid stays 1, data stable, req_ready=0. rsp_ready=1 -> IDLE, then the pending request is accepted.
- Reset pulse asserted in WAIT -> all outputs return to zero immediately. After release, ADD 2+2 completes with rsp_data=4 and op_count=1. Also set op_count to 0xFFFF via 65535 ops (or force) then one more op -> op_count=0.
